// File: rtl/rr_mux_4_1.sv
// 4-to-1 valid/ready stream mux with round-robin arbitration and a registered output stage.
// Optional packet locking is enabled by defining RR_MUX_PKT_LOCK_EN.
module rr_mux_4_1 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  output logic [3:0]         in_ready,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  output logic               out_last
);

  logic [1:0]       ptr_r;
  logic             load_en_s;
  logic             grant_ok_s;
  logic [1:0]       grant_s;
  logic [3:0]       eligible_s;
  logic             hs_s;
  logic [WIDTH-1:0] grant_data_s;

`ifdef RR_MUX_PKT_LOCK_EN
  logic       lock_r;
  logic [1:0] lock_ch_r;
`else
  logic unused_last_s;
  assign unused_last_s = ^in_last;
`endif

  // Returns {found, index} of the first set bit of req scanning from start upward, modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!pick[2] && req[idx]) begin
        pick = {1'b1, idx};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Grant selection and one-hot ready generation.
  always_comb begin
    load_en_s = !out_valid || out_ready;
`ifdef RR_MUX_PKT_LOCK_EN
    if (lock_r) begin
      eligible_s = in_valid & (4'b0001 << lock_ch_r);
    end else begin
      eligible_s = in_valid;
    end
`else
    eligible_s = in_valid;
`endif
    {grant_ok_s, grant_s} = rr_pick(eligible_s, ptr_r);
    if (rst_n && load_en_s && grant_ok_s) begin
      in_ready = 4'b0001 << grant_s;
    end else begin
      in_ready = 4'b0000;
    end
    hs_s         = |(in_valid & in_ready);
    grant_data_s = in_data[grant_s*WIDTH +: WIDTH];
  end

  // Output register, round-robin pointer and packet lock state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      out_last  <= 1'b0;
      ptr_r     <= 2'd0;
`ifdef RR_MUX_PKT_LOCK_EN
      lock_r    <= 1'b0;
      lock_ch_r <= 2'd0;
`endif
    end else if (hs_s) begin
      out_valid <= 1'b1;
      out_data  <= grant_data_s;
      out_sel   <= grant_s;
`ifdef RR_MUX_PKT_LOCK_EN
      out_last  <= in_last[grant_s];
      // Mid-packet beats hold the pointer so the scan resumes after the whole packet.
      if (in_last[grant_s]) begin
        lock_r <= 1'b0;
        ptr_r  <= grant_s + 2'd1;
      end else begin
        lock_r    <= 1'b1;
        lock_ch_r <= grant_s;
        ptr_r     <= ptr_r;
      end
`else
      out_last  <= 1'b0;
      ptr_r     <= grant_s + 2'd1;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_rr_mux_4_1.sv
// Self-checking bench for rr_mux_4_1: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_rr_mux_4_1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_last;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef RR_MUX_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  // Behavioural model state: next channel to look at first, lock, and the output beat.
  int         m_ptr;
  bit         m_lock;
  int         m_lch;
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_sel;
  logic       m_last;

  rr_mux_4_1 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_ptr = 0; m_lock = 0; m_lch = 0;
    m_valid = 1'b0; m_data = 8'h00; m_sel = 2'd0; m_last = 1'b0;
  endtask

  // Channel granted this cycle under the current inputs, or -1.
  function automatic int m_grant();
    int c;
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < 4; k++) begin
      c = (m_ptr + k) % 4;
      if (LOCK && m_lock && c != m_lch) continue;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    int g;
    g = m_grant();
    if (g < 0) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  task automatic m_edge();
    int g;
    g = m_grant();
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = in_data[g*8 +: 8];
      m_sel   = 2'(g);
      m_last  = LOCK ? in_last[g] : 1'b0;
      if (LOCK && !in_last[g]) begin
        m_lock = 1; m_lch = g;
      end else begin
        m_lock = 0; m_ptr = (g + 1) % 4;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_sel !== 2'd0) begin n_bad++; $display("FAIL rst_sel: got %0d want 0", out_sel); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", out_data); end
    n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready: got %b want 0000", in_ready); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL rst_first_rdy: got %b want 0001", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'h11) begin
      n_bad++; $display("FAIL rst_first_beat: got v=%b sel=%0d d=%h want v=1 sel=0 d=11", out_valid, out_sel, out_data);
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_single();
    in_valid = 4'b0100; in_data = {8'h00, 8'hA5, 8'h00, 8'h00}; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL single_rdy: got %b want 0100", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 2'd2) begin
      n_bad++; $display("FAIL single_beat: got v=%b d=%h sel=%0d want v=1 d=a5 sel=2", out_valid, out_data, out_sel);
    end
    in_valid = 4'b0000;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_sel !== 2'd2) begin
      n_bad++; $display("FAIL single_drain: got v=%b d=%h sel=%0d want v=0 d=a5 sel=2", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_wrap_skip();
    in_valid = 4'b0011; in_data = {8'h23, 8'h22, 8'h21, 8'h20};
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL wrap_rdy0: got %b want 0001", in_ready); end
    tick();
    n_cmp++; if (out_sel !== 2'd0 || out_data !== 8'h20) begin n_bad++; $display("FAIL wrap_beat0: got sel=%0d d=%h want sel=0 d=20", out_sel, out_data); end
    #1;
    n_cmp++; if (in_ready !== 4'b0010) begin n_bad++; $display("FAIL wrap_rdy1: got %b want 0010", in_ready); end
    tick();
    n_cmp++; if (out_sel !== 2'd1 || out_data !== 8'h21) begin n_bad++; $display("FAIL wrap_beat1: got sel=%0d d=%h want sel=1 d=21", out_sel, out_data); end
    in_valid = 4'b1000;
    #1;
    n_cmp++; if (in_ready !== 4'b1000) begin n_bad++; $display("FAIL wrap_rdy3: got %b want 1000", in_ready); end
    tick();
    n_cmp++; if (out_sel !== 2'd3 || out_data !== 8'h23) begin n_bad++; $display("FAIL wrap_beat3: got sel=%0d d=%h want sel=3 d=23", out_sel, out_data); end
  endtask

  task automatic test_full_load();
    logic [7:0] exp_d;
    in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 12; k++) begin
      if (k == 8) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_rdy: got %b want 0000", in_ready); end
          tick();
          n_cmp++; if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 8'h13) begin
            n_bad++; $display("FAIL stall_hold: got v=%b sel=%0d d=%h want v=1 sel=3 d=13", out_valid, out_sel, out_data);
          end
        end
        out_ready = 1'b1;
      end
      #1;
      n_cmp++; if (in_ready !== (4'b0001 << (k % 4))) begin n_bad++; $display("FAIL full_rdy%0d: got %b want %b", k, in_ready, 4'b0001 << (k % 4)); end
      tick();
      exp_d = 8'h10 + 8'(k % 4);
      n_cmp++; if (out_valid !== 1'b1 || out_sel !== 2'(k % 4) || out_data !== exp_d) begin
        n_bad++; $display("FAIL full_beat%0d: got v=%b sel=%0d d=%h want v=1 sel=%0d d=%h", k, out_valid, out_sel, out_data, k % 4, exp_d);
      end
    end
    in_valid = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_pkt_lock();
    int b1;
    int g;
    int exp_sel[4];
    int exp_last[4];
    if (LOCK) begin
      exp_sel = '{1, 1, 1, 2}; exp_last = '{0, 0, 1, 1};
    end else begin
      exp_sel = '{1, 2, 0, 1}; exp_last = '{0, 0, 0, 0};
    end
    in_valid = 4'b0001; in_last = 4'b1111; in_data = {8'h33, 8'h32, 8'h31, 8'h30};
    tick();
    n_cmp++; if (out_sel !== 2'd0) begin n_bad++; $display("FAIL pkt_pre: got sel=%0d want 0", out_sel); end
    b1 = 0;
    for (int j = 0; j < 4; j++) begin
      in_valid = {1'b0, 1'b1, (b1 < 3), 1'b1};
      in_last  = {1'b1, 1'b1, (b1 == 2), 1'b1};
      in_data[15:8] = 8'h40 + 8'(b1);
      g = m_grant();
      #1;
      n_cmp++; if (in_ready !== m_ready()) begin n_bad++; $display("FAIL pkt_rdy%0d: got %b want %b", j, in_ready, m_ready()); end
      tick();
      if (g == 1) b1++;
      n_cmp++; if (out_sel !== 2'(exp_sel[j]) || out_last !== 1'(exp_last[j])) begin
        n_bad++; $display("FAIL pkt_beat%0d: got sel=%0d last=%b want sel=%0d last=%0d", j, out_sel, out_last, exp_sel[j], exp_last[j]);
      end
    end
    in_valid = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [3:0] pend;
    logic [7:0] dat[4];
    logic [3:0] lst;
    int g;
    pend = 4'b0000; lst = 4'b0000;
    for (int c = 0; c < 4; c++) dat[c] = 8'h00;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (!pend[c] && $urandom_range(0, 2) != 0) begin
          pend[c] = 1'b1;
          dat[c]  = 8'($urandom);
          lst[c]  = 1'($urandom_range(0, 1));
        end
      end
      in_valid  = pend;
      in_data   = {dat[3], dat[2], dat[1], dat[0]};
      in_last   = lst;
      out_ready = ($urandom_range(0, 3) != 0);
      g = m_grant();
      #1;
      n_cmp++; if (in_ready !== m_ready()) begin n_bad++; $display("FAIL rnd_rdy@%0d: got %b want %b", n, in_ready, m_ready()); end
      tick();
      if (g >= 0) pend[g] = 1'b0;
      n_cmp++; if (out_valid !== m_valid || out_data !== m_data || out_sel !== m_sel || out_last !== m_last) begin
        n_bad++; $display("FAIL rnd_out@%0d: got v=%b d=%h sel=%0d last=%b want v=%b d=%h sel=%0d last=%b",
                          n, out_valid, out_data, out_sel, out_last, m_valid, m_data, m_sel, m_last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap_skip();
    test_full_load();
    test_pkt_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
